// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, reset PC
// default and instruction field positions.
package instr_fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int JIDX_MSB   = 25;
  localparam int IMM_MSB    = 15;

endpackage

// File: rtl/instr_fetch_unit_next_pc_logic.sv
// Purely combinational next-PC selection from the resolved control flags,
// plus the jr-target misalignment flag.
module next_pc_logic
  import instr_fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic        branch,
  input  logic        bne,
  input  logic        zero,
  input  logic        jump,
  input  logic        jal,
  input  logic        jr,
  input  logic [31:0] rs_data,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  logic        [31:0] pc4;
  logic signed [31:0] br_off;
  logic        [31:0] btgt;
  logic        [31:0] jtgt;
  logic               taken;

  // All additions wrap modulo 2^32 by construction of the 32-bit widths.
  assign pc4    = pc + 32'd4;
  assign br_off = $signed({{14{instr[IMM_MSB]}}, instr[IMM_MSB:0], 2'b00});
  assign btgt   = pc4 + $unsigned(br_off);
  assign jtgt   = {pc4[31:28], instr[JIDX_MSB:0], 2'b00};
  assign taken  = (branch & zero) | (bne & ~zero);

  always_comb begin
    next_pc = pc4;
    if (jr)
      next_pc = {rs_data[31:2], 2'b00};
    else if (jump | jal)
      next_pc = jtgt;
    else if (taken)
      next_pc = btgt;
  end

  assign misaligned = jr & (|rs_data[1:0]);

endmodule

// File: rtl/instr_fetch_unit.sv
// Multi-cycle in-order fetch: holds the PC, fetches one word per downstream
// ack over a ready handshake, and advances the PC from resolved control flags.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [31:0] pc_out,
  output logic [31:0] link_addr,
  input  logic        instr_ack,
  input  logic        branch,
  input  logic        bne,
  input  logic        zero,
  input  logic        jump,
  input  logic        jal,
  input  logic        jr,
  input  logic [31:0] rs_data,
  output logic        addr_err
);

  fetch_state_e state, state_nxt;
  logic [31:0]  pc;
  logic [31:0]  next_pc;
  logic         misaligned;
  logic         fetch_done;
  logic         retire;

  next_pc_logic u_next_pc (
    .pc         (pc),
    .instr      (instr),
    .branch     (branch),
    .bne        (bne),
    .zero       (zero),
    .jump       (jump),
    .jal        (jal),
    .jr         (jr),
    .rs_data    (rs_data),
    .next_pc    (next_pc),
    .misaligned (misaligned)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // imem_ready only matters in FETCH and instr_ack only in HOLD.
  always_comb begin
    state_nxt  = state;
    fetch_done = 1'b0;
    retire     = 1'b0;
    case (state)
      IDLE:  state_nxt = FETCH;
      FETCH: if (imem_ready) begin
        fetch_done = 1'b1;
        state_nxt  = HOLD;
      end
      HOLD:  if (instr_ack) begin
        retire    = 1'b1;
        state_nxt = FETCH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= RESET_PC;
      instr    <= 32'h0;
      addr_err <= 1'b0;
    end else begin
      if (fetch_done) instr <= imem_rdata;
      if (retire) begin
        pc <= next_pc;
        if (misaligned) addr_err <= 1'b1;
      end
    end
  end

  // The PC only advances on retire, so it still names the held instruction.
  assign imem_req    = (state == FETCH);
  assign imem_addr   = pc;
  assign instr_valid = (state == HOLD);
  assign pc_out      = pc;
  assign link_addr   = pc + 32'd4;
  assign opcode      = instr[OPCODE_MSB:OPCODE_LSB];

endmodule
